// File: rtl/matrix_scanner.sv
// ============================================================================
// Module   : matrix_scanner
// Brief    : Column-scanned driver for a 5x7 LED matrix, mirroring three
//            half-image column words onto five columns with per-slot blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_scanner #(
    parameter int TICKS_PER_COLUMN = 1000,
    parameter int BLANK_TICKS      = 50
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [6:0] col_2,
    input  logic [6:0] col_1,
    input  logic [6:0] col_0,
    output logic [4:0] columns,
    output logic [6:0] rows,
    output logic       frame_start
);

    localparam int            PW      = (TICKS_PER_COLUMN > 1) ? $clog2(TICKS_PER_COLUMN) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(TICKS_PER_COLUMN - 1);
    localparam logic [PW:0]   BLANK_W = (PW + 1)'(BLANK_TICKS);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    s2_q, s2_d, s1_q, s1_d, s0_q, s0_d;
    logic [4:0]    columns_q, columns_d;
    logic [6:0]    rows_q, rows_d;
    logic          frame_start_q, frame_start_d;
    logic          load;
    logic          lit;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            p_q           <= '0;
            idx_q         <= 3'd0;
            s2_q          <= 7'd0;
            s1_q          <= 7'd0;
            s0_q          <= 7'd0;
            columns_q     <= 5'b11111;
            rows_q        <= 7'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            idx_q         <= idx_d;
            s2_q          <= s2_d;
            s1_q          <= s1_d;
            s0_q          <= s0_d;
            columns_q     <= columns_d;
            rows_q        <= rows_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        idx_d         = idx_q;
        s2_d          = s2_q;
        s1_d          = s1_q;
        s0_d          = s0_q;
        frame_start_d = 1'b0;
        load          = 1'b0;
        columns_d     = 5'b11111;
        rows_d        = 7'd0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SCAN;
                    p_d     = '0;
                    idx_d   = 3'd0;
                    load    = 1'b1;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                    p_d     = '0;
                    idx_d   = 3'd0;
                end else begin
                    if (p_q != P_LAST) begin
                        p_d = p_q + 1'b1;
                    end else begin
                        p_d   = '0;
                        idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
                    end
                    load = (p_d == '0) && (idx_d == 3'd0);
                end
            end
            default: state_d = IDLE;
        endcase

        // Shadows only move at frame boundaries so a frame is never torn.
        if (load) begin
            s2_d          = col_2;
            s1_d          = col_1;
            s0_d          = col_0;
            frame_start_d = 1'b1;
        end

        // Drive from post-edge state so the registered outputs match it.
        lit = (state_d == SCAN) && !({1'b0, p_d} < BLANK_W);
        if (lit) begin
            case (idx_d)
                3'd0:    begin columns_d = 5'b11110; rows_d = s2_d; end
                3'd1:    begin columns_d = 5'b11101; rows_d = s1_d; end
                3'd2:    begin columns_d = 5'b11011; rows_d = s0_d; end
                3'd3:    begin columns_d = 5'b10111; rows_d = s1_d; end
                3'd4:    begin columns_d = 5'b01111; rows_d = s2_d; end
                default: begin columns_d = 5'b11111; rows_d = 7'd0; end
            endcase
        end
    end

    assign columns     = columns_q;
    assign rows        = rows_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scanner.sv
// ============================================================================
// Module   : tb_matrix_scanner
// Brief    : Directed self-checking bench for matrix_scanner (8 ticks/column,
//            2 blank ticks) with a small cycle model of the scan.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_scanner;

    localparam int TPC   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 5 * TPC;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic [6:0] col_2, col_1, col_0;
    logic [4:0] columns;
    logic [6:0] rows;
    logic       frame_start;

    int n_checks;
    int n_errors;
    int cyc;
    logic [6:0] m2, m1, m0;

    matrix_scanner #(
        .TICKS_PER_COLUMN(TPC),
        .BLANK_TICKS     (BLANK)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .col_2      (col_2),
        .col_1      (col_1),
        .col_0      (col_0),
        .columns    (columns),
        .rows       (rows),
        .frame_start(frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 'h%0h, expected 'h%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_cols"}, int'(columns), 5'b11111);
        check({tag, "_rows"}, int'(rows), 0);
        check({tag, "_fs"}, int'(frame_start), 0);
    endtask

    // Runs n enabled scan cycles, checking each against the reference model.
    task automatic run(input int n, input bit rnd);
        int         p, idx;
        logic [4:0] e_cols;
        logic [6:0] e_rows;
        bit         ok;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                col_2 = 7'($urandom);
                col_1 = 7'($urandom);
                col_0 = 7'($urandom);
            end
            step();
            cyc++;
            if (cyc % FRAME == 0) begin
                m2 = col_2;
                m1 = col_1;
                m0 = col_0;
            end
            p   = cyc % TPC;
            idx = (cyc / TPC) % 5;
            if (p < BLANK) begin
                e_cols = 5'b11111;
                e_rows = 7'd0;
            end else begin
                e_cols = 5'b11111;
                e_cols[idx] = 1'b0;
                case (idx)
                    0, 4:    e_rows = m2;
                    1, 3:    e_rows = m1;
                    default: e_rows = m0;
                endcase
            end
            check("scan_cols", int'(columns), int'(e_cols));
            check("scan_rows", int'(rows), int'(e_rows));
            check("scan_fs", int'(frame_start), (cyc % FRAME == 0) ? 1 : 0);
            ok = (columns == 5'b11111) || (columns == 5'b11110) || (columns == 5'b11101) ||
                 (columns == 5'b11011) || (columns == 5'b10111) || (columns == 5'b01111);
            check("onehot", int'(ok), 1);
            if (columns == 5'b11111) check("blank_rows_zero", int'(rows), 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m2 = 7'd0; m1 = 7'd0; m0 = 7'd0;

        // Reset held with enable high and all-ones image.
        reset_n = 1'b0;
        enable  = 1'b1;
        col_2 = 7'h7F; col_1 = 7'h7F; col_0 = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            step();
            check_blank("reset");
        end

        reset_n = 1'b1;
        enable  = 1'b0;
        step();
        check_blank("idle");

        // Mirror mapping, then a mid-frame input change that must not tear.
        col_2 = 7'h41; col_1 = 7'h22; col_0 = 7'h14;
        enable = 1'b1;
        cyc = -1;
        run(21, 1'b0);
        col_1 = 7'h7F;
        run(35, 1'b0);
        run(12, 1'b0);

        // Enable dropped at the equivalent of cycle 28 of the second frame.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_blank("disabled");
        end

        // Re-enable with new data; column 0 lit two cycles after frame_start.
        col_2 = 7'h11; col_1 = 7'h33; col_0 = 7'h55;
        enable = 1'b1;
        cyc = -1;
        run(17, 1'b0);

        // Reset mid-scan for one edge at cycle 17.
        reset_n = 1'b0;
        step();
        check_blank("reset_mid");
        reset_n = 1'b1;

        // Restart with enable held; random inputs over three frames.
        cyc = -1;
        run(3 * FRAME, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
